// File: rtl/ff_grad_pkg.sv
// Shared types and constants for the FF-STDP negative-phase weight update.
// Holds the FSM state encoding, default widths and saturation bounds.
package ff_grad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROMREQ,
    ST_ROMWAIT,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } grad_state_e;

  localparam int PRE_NUM_DEF      = 256;
  localparam int POST_NUM_DEF     = 16;
  localparam int WEIGHT_WIDTH_DEF = 8;
  localparam int TRACE_WIDTH_DEF  = 8;
  localparam int DERIV_WIDTH_DEF  = 9;
  localparam int LR_SHIFT_DEF     = 4;

  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  localparam int W_SAT_MAX = sat_max(WEIGHT_WIDTH_DEF);
  localparam int W_SAT_MIN = -W_SAT_MAX - 1;

endpackage

// File: rtl/ff_neg_grad_update_if.sv
// Control, derivative-ROM, trace-memory and weight-SRAM signals of the update block.
// The update block connects through the slave modport; its environment uses master.
interface ff_neg_grad_update_if #(
  parameter int PRE_NUM      = 256,
  parameter int POST_NUM     = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int TRACE_WIDTH  = 8,
  parameter int DERIV_WIDTH  = 9
);
  localparam int PRE_AW  = $clog2(PRE_NUM);
  localparam int POST_AW = $clog2(POST_NUM);
  localparam int W_AW    = PRE_AW + POST_AW;

  logic                           start;
  logic        [POST_AW-1:0]      post_idx;
  logic        [7:0]              deriv_addr;
  logic                           busy;
  logic                           done;
  logic        [7:0]              rom_addr;
  logic signed [DERIV_WIDTH-1:0]  rom_dout;
  logic                           tr_ren;
  logic        [PRE_AW-1:0]       tr_raddr;
  logic        [TRACE_WIDTH-1:0]  tr_rdata;
  logic                           w_ren;
  logic        [W_AW-1:0]         w_raddr;
  logic signed [WEIGHT_WIDTH-1:0] w_rdata;
  logic                           w_wen;
  logic        [W_AW-1:0]         w_waddr;
  logic signed [WEIGHT_WIDTH-1:0] w_wdata;

  modport slave (
    input  start, post_idx, deriv_addr, rom_dout, tr_rdata, w_rdata,
    output busy, done, rom_addr, tr_ren, tr_raddr, w_ren, w_raddr, w_wen, w_waddr, w_wdata
  );

  modport master (
    output start, post_idx, deriv_addr, rom_dout, tr_rdata, w_rdata,
    input  busy, done, rom_addr, tr_ren, tr_raddr, w_ren, w_raddr, w_wen, w_waddr, w_wdata
  );

endinterface

// File: rtl/ff_grad_sat_mac.sv
// Combinational weight update: w + ((deriv * trace) >>> LR_SHIFT), saturated to the
// signed weight range. Trace is unsigned and is zero-extended before the multiply.
module ff_grad_sat_mac
  import ff_grad_pkg::*;
#(
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int TRACE_WIDTH  = TRACE_WIDTH_DEF,
  parameter int DERIV_WIDTH  = DERIV_WIDTH_DEF,
  parameter int LR_SHIFT     = LR_SHIFT_DEF
) (
  input  logic signed [DERIV_WIDTH-1:0]  i_deriv,
  input  logic        [TRACE_WIDTH-1:0]  i_trace,
  input  logic signed [WEIGHT_WIDTH-1:0] i_weight,
  output logic signed [WEIGHT_WIDTH-1:0] o_weight
);
  localparam int PROD_W = DERIV_WIDTH + TRACE_WIDTH + 1;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(sat_max(WEIGHT_WIDTH));
  localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;

  function automatic logic signed [WEIGHT_WIDTH-1:0] sat_w(input logic signed [SUM_W-1:0] s);
    if (s > SAT_HI)      sat_w = SAT_HI[WEIGHT_WIDTH-1:0];
    else if (s < SAT_LO) sat_w = SAT_LO[WEIGHT_WIDTH-1:0];
    else                 sat_w = s[WEIGHT_WIDTH-1:0];
  endfunction

  logic signed [PROD_W-1:0] w_deriv_ext;
  logic signed [PROD_W-1:0] w_trace_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_delta;
  logic signed [SUM_W-1:0]  w_sum;

  always_comb begin
    w_deriv_ext = PROD_W'(i_deriv);
    w_trace_ext = PROD_W'(i_trace);
    w_prod      = w_deriv_ext * w_trace_ext;
    w_delta     = w_prod >>> LR_SHIFT;
    w_sum       = SUM_W'(i_weight) + SUM_W'(w_delta);
    o_weight    = sat_w(w_sum);
  end

endmodule

// File: rtl/ff_neg_grad_update.sv
// Negative-phase weight-row update: derivative lookup, streamed read/update/write of one row.
// Optional FF_GRAD_ZERO_SKIP_EN: a zero derivative skips the row pass entirely.
module ff_neg_grad_update
  import ff_grad_pkg::*;
#(
  parameter int PRE_NUM      = PRE_NUM_DEF,
  parameter int POST_NUM     = POST_NUM_DEF,
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int TRACE_WIDTH  = TRACE_WIDTH_DEF,
  parameter int DERIV_WIDTH  = DERIV_WIDTH_DEF,
  parameter int LR_SHIFT     = LR_SHIFT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ff_neg_grad_update_if.slave  bus
);
  localparam int PRE_AW  = $clog2(PRE_NUM);
  localparam int POST_AW = $clog2(POST_NUM);
  localparam int W_AW    = PRE_AW + POST_AW;

  grad_state_e                    r_state;
  logic        [POST_AW-1:0]      r_post;
  logic        [7:0]              r_rom_addr;
  logic signed [DERIV_WIDTH-1:0]  r_deriv_q;
  logic        [PRE_AW-1:0]       r_pre;
  logic                           r_drain;
  logic                           r_busy;
  logic                           r_done;
  logic                           r_ren_p0;
  logic                           r_vld_p1;
  logic        [W_AW-1:0]         r_addr_p1;
  logic                           r_wen_p2;
  logic        [W_AW-1:0]         r_waddr_p2;
  logic signed [WEIGHT_WIDTH-1:0] r_wdata_p2;
  logic signed [WEIGHT_WIDTH-1:0] w_new_wt;

  ff_grad_sat_mac #(
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .TRACE_WIDTH  (TRACE_WIDTH),
    .DERIV_WIDTH  (DERIV_WIDTH),
    .LR_SHIFT     (LR_SHIFT)
  ) u_mac (
    .i_deriv  (r_deriv_q),
    .i_trace  (bus.tr_rdata),
    .i_weight (bus.w_rdata),
    .o_weight (w_new_wt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_post     <= '0;
      r_rom_addr <= '0;
      r_deriv_q  <= '0;
      r_pre      <= '0;
      r_drain    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ren_p0   <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_addr_p1  <= '0;
      r_wen_p2   <= 1'b0;
      r_waddr_p2 <= '0;
      r_wdata_p2 <= '0;
    end else begin
      // p0 -> p1: memory read data arrives alongside its address
      r_vld_p1  <= r_ren_p0;
      r_addr_p1 <= {r_post, r_pre};
      // p1 -> p2: registered write-back of the updated weight
      r_wen_p2  <= r_vld_p1;
      if (r_vld_p1) begin
        r_waddr_p2 <= r_addr_p1;
        r_wdata_p2 <= w_new_wt;
      end
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_post     <= bus.post_idx;
            r_rom_addr <= bus.deriv_addr;
            r_busy     <= 1'b1;
            r_state    <= ST_ROMREQ;
          end
        end
        ST_ROMREQ: r_state <= ST_ROMWAIT;
        ST_ROMWAIT: begin
          r_deriv_q <= bus.rom_dout;
`ifdef FF_GRAD_ZERO_SKIP_EN
          if (bus.rom_dout == '0) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_ren_p0 <= 1'b1;
            r_pre    <= '0;
            r_state  <= ST_RUN;
          end
`else
          r_ren_p0 <= 1'b1;
          r_pre    <= '0;
          r_state  <= ST_RUN;
`endif
        end
        ST_RUN: begin
          if (r_pre == PRE_AW'(PRE_NUM - 1)) begin
            r_ren_p0 <= 1'b0;
            r_drain  <= 1'b0;
            r_state  <= ST_DRAIN;
          end else begin
            r_pre <= r_pre + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_drain <= 1'b1;
          end
        end
        ST_DONE: begin
          r_busy     <= 1'b0;
          r_rom_addr <= '0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rom_addr = r_rom_addr;
  assign bus.tr_ren   = r_ren_p0;
  assign bus.tr_raddr = r_pre;
  assign bus.w_ren    = r_ren_p0;
  assign bus.w_raddr  = {r_post, r_pre};
  assign bus.w_wen    = r_wen_p2;
  assign bus.w_waddr  = r_waddr_p2;
  assign bus.w_wdata  = r_wdata_p2;

endmodule

// File: tb/tb_ff_neg_grad_update.sv
// Directed bench for ff_neg_grad_update: memory models, write monitor, timing and value checks.
// Define FF_GRAD_ZERO_SKIP_EN when building with the zero-skip option enabled.
module tb_ff_neg_grad_update;
  import ff_grad_pkg::*;

  localparam int PRE_NUM = PRE_NUM_DEF;
  localparam int PRE_AW  = $clog2(PRE_NUM_DEF);
  localparam int POST_AW = $clog2(POST_NUM_DEF);
  localparam int W_AW    = PRE_AW + POST_AW;
  localparam int FULL_DONE = PRE_NUM + 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ff_neg_grad_update_if #(
    .PRE_NUM(PRE_NUM_DEF), .POST_NUM(POST_NUM_DEF), .WEIGHT_WIDTH(WEIGHT_WIDTH_DEF),
    .TRACE_WIDTH(TRACE_WIDTH_DEF), .DERIV_WIDTH(DERIV_WIDTH_DEF)
  ) bus ();

  ff_neg_grad_update dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic signed [DERIV_WIDTH_DEF-1:0]  rom  [256];
  logic        [TRACE_WIDTH_DEF-1:0]  tr_mem [PRE_NUM];
  logic signed [WEIGHT_WIDTH_DEF-1:0] wmem [1 << W_AW];

  // Registered ROM and synchronous read memories; DUT writes are only observed, not stored.
  always @(posedge clk) begin
    bus.rom_dout <= rom[bus.rom_addr];
    if (bus.tr_ren) bus.tr_rdata <= tr_mem[bus.tr_raddr];
    if (bus.w_ren)  bus.w_rdata  <= wmem[bus.w_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int d, input int t, input int w);
    int p, dl, s;
    p = d * t;
    if (p >= 0) dl = p / (1 << LR_SHIFT_DEF);
    else        dl = -((-p + (1 << LR_SHIFT_DEF) - 1) / (1 << LR_SHIFT_DEF));
    s = w + dl;
    if (s > W_SAT_MAX) s = W_SAT_MAX;
    if (s < W_SAT_MIN) s = W_SAT_MIN;
    return s;
  endfunction

  int orig [PRE_NUM];
  int exp_deriv, exp_post, s_cyc;
  int nwr = 0, bad_val = 0, bad_tim = 0, bad_addr = 0;
  int w0_data = 0, w0_abs = 0;
  int mj, mexp;

  always @(negedge clk) begin
    if (bus.w_wen) begin
      mj   = int'(bus.w_waddr[PRE_AW-1:0]);
      mexp = model(exp_deriv, int'(tr_mem[mj]), orig[mj]);
      nwr++;
      if (int'(bus.w_wdata) != mexp) bad_val++;
      if (cyc != s_cyc + 5 + mj) bad_tim++;
      if (int'(bus.w_waddr[W_AW-1:PRE_AW]) != exp_post) bad_addr++;
      if (mj == 0) begin
        w0_data = int'(bus.w_wdata);
        w0_abs  = cyc;
      end
    end
  end

  task automatic prep(input int post, input int daddr);
    for (int j = 0; j < PRE_NUM; j++) orig[j] = int'(wmem[post * PRE_NUM + j]);
    exp_deriv = int'(rom[daddr]);
    exp_post  = post;
  endtask

  task automatic run_op(input string tag, input int post, input int daddr, input int inj_at,
                        input int exp_done, input int exp_nwr, input int exp_w0);
    int n0, bv0, bt0, ba0, got_d;
    prep(post, daddr);
    n0 = nwr; bv0 = bad_val; bt0 = bad_tim; ba0 = bad_addr;
    @(negedge clk);
    bus.start = 1'b1; bus.post_idx = POST_AW'(post); bus.deriv_addr = 8'(daddr);
    s_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    check_val({tag, ".busy1"}, longint'(bus.busy), 1);
    check_val({tag, ".romaddr"}, longint'(bus.rom_addr), daddr);
    got_d = -1;
    for (int k = 0; k < 400; k++) begin
      if (bus.done) begin
        got_d = cyc - s_cyc;
        break;
      end
      @(negedge clk);
      if (inj_at >= 0 && cyc - s_cyc == inj_at) begin
        bus.start = 1'b1;
        bus.post_idx = POST_AW'((post + 5) % 16);
      end else begin
        bus.start = 1'b0;
        bus.post_idx = POST_AW'(post);
      end
    end
    bus.start = 1'b0;
    check_val({tag, ".done_at"}, got_d, exp_done);
    @(negedge clk);
    check_val({tag, ".done_pulse"}, longint'(bus.done), 0);
    check_val({tag, ".busy_end"}, longint'(bus.busy), 0);
    check_val({tag, ".nwr"}, nwr - n0, exp_nwr);
    check_val({tag, ".bad_val"}, bad_val - bv0, 0);
    check_val({tag, ".bad_tim"}, bad_tim - bt0, 0);
    check_val({tag, ".bad_row"}, bad_addr - ba0, 0);
    if (exp_nwr > 0) begin
      check_val({tag, ".w0"}, w0_data, exp_w0);
      check_val({tag, ".w0_at"}, w0_abs - s_cyc, 5);
    end
  endtask

  task automatic fill_pattern();
    for (int j = 0; j < PRE_NUM; j++) tr_mem[j] = 8'((j * 29 + 7) % 256);
    tr_mem[0] = 8'd255;
  endtask

  initial begin
    int n0, found;
    bus.start = 1'b0; bus.post_idx = '0; bus.deriv_addr = '0;
    for (int a = 0; a < 256; a++) rom[a] = '0;
    rom[8'h11] = -9'sd1;
    rom[8'h22] = -9'sd7;
    rom[8'h33] = 9'sd255;
    for (int a = 0; a < (1 << W_AW); a++) wmem[a] = 8'((a * 37 + 11) % 256);
    wmem[3 * 256] = 8'sd10;
    wmem[5 * 256] = -8'sd120;
    wmem[7 * 256] = 8'sd100;
    wmem[2 * 256] = 8'sd33;
    s_cyc = 0; exp_deriv = 0; exp_post = 0;
    for (int j = 0; j < PRE_NUM; j++) orig[j] = 0;

    repeat (3) @(negedge clk);
    check_val("reset.ctl", longint'({bus.busy, bus.done, bus.tr_ren, bus.w_ren, bus.w_wen}), 0);
    check_val("reset.addr", longint'({bus.rom_addr, bus.tr_raddr, bus.w_raddr, bus.w_waddr}), 0);
    check_val("reset.wdata", longint'(bus.w_wdata), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int j = 0; j < PRE_NUM; j++) tr_mem[j] = 8'd255;
    run_op("neg1", 3, 8'h11, -1, FULL_DONE, PRE_NUM, -6);

    fill_pattern();
    run_op("satlo", 5, 8'h22, -1, FULL_DONE, PRE_NUM, -128);
    run_op("sathi", 7, 8'h33, -1, FULL_DONE, PRE_NUM, 127);

    for (int j = 0; j < PRE_NUM; j++) tr_mem[j] = 8'd0;
    run_op("trzero", 1, 8'h11, -1, FULL_DONE, PRE_NUM, 11);

    fill_pattern();
`ifdef FF_GRAD_ZERO_SKIP_EN
    run_op("dzero", 2, 8'h00, -1, 3, 0, 0);
`else
    run_op("dzero", 2, 8'h00, -1, FULL_DONE, PRE_NUM, 33);
`endif

    run_op("ignstart", 4, 8'h11, 50, FULL_DONE, PRE_NUM, -5);

    prep(6, 8'h11);
    @(negedge clk);
    bus.start = 1'b1; bus.post_idx = POST_AW'(6); bus.deriv_addr = 8'h11;
    s_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    found = 0;
    for (int k = 0; k < 300; k++) begin
      if (bus.tr_ren && int'(bus.tr_raddr) == 100) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check_val("rst.reach100", found, 1);
    rst_n = 1'b0;
    #1;
    check_val("rst.ctl", longint'({bus.busy, bus.done, bus.tr_ren, bus.w_ren, bus.w_wen}), 0);
    check_val("rst.addr", longint'({bus.rom_addr, bus.tr_raddr, bus.w_raddr, bus.w_waddr}), 0);
    check_val("rst.wdata", longint'(bus.w_wdata), 0);
    @(negedge clk);
    n0 = nwr;
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_val("rst.nowrites", nwr - n0, 0);
    check_val("rst.idle", longint'({bus.busy, bus.w_wen}), 0);
    run_op("rerun", 6, 8'h11, -1, FULL_DONE, PRE_NUM, -5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
